rsqrt_table_gen: RTL and testbench

- Hardware writer for the normalizer's 1/sqrt(x) coefficient table. Replaces the bus-driven load of 2^TWIDTH words.
- On start: pulses the table address clear, then computes K[a] for a = 0..2^TWIDTH-1 with a bit-serial integer square root and a restoring divider.
- Streams each K[a] out through a valid/ready word interface. The interface connects to the normalizer table write strobe/data; tie tbl_ready high when driving it directly.
- Sits beside the normalizer in the DSP chain.

---
 rtl/rsqrt_table_pkg.sv | 26 ++
 rtl/rsqrt_table_gen_if.sv | 20 ++
 rtl/isqrt_serial.sv | 56 +++++
 rtl/rsqrt_table_gen.sv | 170 +++++++++++++++++
 tb/tb_rsqrt_table_gen.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/rsqrt_table_pkg.sv
// Shared types and width helpers for the 1/sqrt(x) coefficient table generator.
package rsqrt_table_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SQRT  = 3'd2,
        DIV   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Radicand is (4a+2) scaled by 2*FRAC fractional bits
    function automatic int rw_f(input int twidth, input int frac);
        return twidth + 2 + 2 * frac;
    endfunction

    function automatic int root_w_f(input int rw);
        return (rw + 1) / 2;
    endfunction

    function automatic int div_w_f(input int numw, input int frac);
        return numw + frac;
    endfunction

endpackage

// File: rtl/rsqrt_table_gen_if.sv
// Control and table-write bus between rsqrt_table_gen and its controller/consumer.
interface rsqrt_table_gen_if #(
    parameter int TWIDTH = 8,
    parameter int NUMW   = 16
);
    logic              start;
    logic [NUMW-1:0]   num;
    logic              tbl_clr;
    logic              tbl_wr;
    logic [TWIDTH-1:0] tbl_data;
    logic              tbl_ready;
    logic              busy;
    logic              done;
    logic [31:0]       tbl_sum;

    modport slave  (input  start, num, tbl_ready,
                    output tbl_clr, tbl_wr, tbl_data, busy, done, tbl_sum);
    modport master (output start, num, tbl_ready,
                    input  tbl_clr, tbl_wr, tbl_data, busy, done, tbl_sum);
endinterface

// File: rtl/isqrt_serial.sv
// Restoring integer square root, two radicand bits per cycle; loads on i_start,
// then iterates ROOTW cycles with o_done high during the last iteration.
module isqrt_serial #(
    parameter int RW    = 16,
    parameter int ROOTW = (RW + 1) / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [RW-1:0]    i_rad,
    output logic             o_done,
    output logic [ROOTW-1:0] o_root
);
    localparam int PW = 2 * ROOTW;
    localparam int CW = $clog2(ROOTW + 1);

    logic [PW-1:0]    r_rad;
    logic [ROOTW-1:0] r_rem;
    logic [ROOTW-1:0] r_root;
    logic [CW-1:0]    r_cnt;

    logic [ROOTW+1:0] w_rem_t;
    logic [ROOTW+1:0] w_trial;
    logic             w_ge;

    // Trial subtraction for the next root bit
    always_comb begin
        w_rem_t = {r_rem, r_rad[PW-1 -: 2]};
        w_trial = {r_root, 2'b01};
        w_ge    = (w_rem_t >= w_trial);
    end

    // Iteration registers; the remainder fits ROOTW bits until the final step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_rad  <= PW'(i_rad);
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= CW'(ROOTW);
        end else if (r_cnt != CW'(0)) begin
            r_rad  <= r_rad << 2;
            r_rem  <= w_ge ? ROOTW'(w_rem_t - w_trial) : ROOTW'(w_rem_t);
            r_root <= {r_root[ROOTW-2:0], w_ge};
            r_cnt  <= r_cnt - CW'(1);
        end
    end

    assign o_done = (r_cnt == CW'(1));
    assign o_root = r_root;

endmodule

// File: rtl/rsqrt_table_gen.sv
// Generates K[a] = min((num<<FRAC)/floor(sqrt((4a+2)<<2FRAC)), 2^TWIDTH-1) for every a.
// Optional running checksum on tbl_sum when RSQRT_TBL_CHECK_EN is defined.
module rsqrt_table_gen
    import rsqrt_table_pkg::*;
#(
    parameter int TWIDTH = 8,
    parameter int FRAC   = 4,
    parameter int NUMW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    rsqrt_table_gen_if.slave bus
);
    localparam int RW    = rw_f(TWIDTH, FRAC);
    localparam int ROOTW = root_w_f(RW);
    localparam int DW    = div_w_f(NUMW, FRAC);
    localparam int CW    = $clog2(DW + 1);
    localparam logic [TWIDTH-1:0] LAST_A = '1;

    state_t            r_state, w_next;
    logic [NUMW-1:0]   r_num;
    logic [TWIDTH-1:0] r_addr;
    logic [DW-1:0]     r_q;
    logic [ROOTW-1:0]  r_p;
    logic [CW-1:0]     r_cnt;
    logic [TWIDTH-1:0] r_data;
    logic              r_clr, r_wr, r_busy, r_done;

    logic              w_xfer, w_last, w_sqrt_start, w_sqrt_done;
    logic [TWIDTH-1:0] w_rad_addr;
    logic [RW-1:0]     w_rad;
    logic [ROOTW-1:0]  w_root;
    logic [ROOTW:0]    w_p_t;
    logic              w_d_ge;
    logic [ROOTW-1:0]  w_p_next;
    logic [DW-1:0]     w_q_next;
    logic [TWIDTH-1:0] w_k;

    // Handshake decode and radicand for the entry about to start
    always_comb begin
        w_xfer       = (r_state == WRITE) && bus.tbl_ready;
        w_last       = (r_addr == LAST_A);
        w_sqrt_start = (r_state == CLR) || (w_xfer && !w_last);
        if (r_state == CLR) begin
            w_rad_addr = '0;
        end else begin
            w_rad_addr = r_addr + TWIDTH'(1);
        end
        w_rad = {w_rad_addr, 2'b10, {(2 * FRAC){1'b0}}};
    end

    isqrt_serial #(.RW(RW), .ROOTW(ROOTW)) u_isqrt (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_sqrt_start),
        .i_rad   (w_rad),
        .o_done  (w_sqrt_done),
        .o_root  (w_root)
    );

    // One restoring-division step plus saturation of the final quotient
    always_comb begin
        w_p_t    = {r_p, r_q[DW-1]};
        w_d_ge   = (w_p_t >= {1'b0, w_root});
        w_p_next = w_d_ge ? ROOTW'(w_p_t - {1'b0, w_root}) : w_p_t[ROOTW-1:0];
        w_q_next = {r_q[DW-2:0], w_d_ge};
        if (|w_q_next[DW-1:TWIDTH]) begin
            w_k = '1;
        end else begin
            w_k = w_q_next[TWIDTH-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? CLR : IDLE;
            CLR:     w_next = SQRT;
            SQRT:    w_next = w_sqrt_done ? DIV : SQRT;
            DIV:     w_next = (r_cnt == CW'(0)) ? WRITE : DIV;
            WRITE: begin
                if (bus.tbl_ready) begin
                    w_next = w_last ? DONE : SQRT;
                end else begin
                    w_next = WRITE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register with registered Moore outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_clr   <= 1'b0;
            r_wr    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_clr   <= (w_next == CLR);
            r_wr    <= (w_next == WRITE);
            r_busy  <= (w_next inside {CLR, SQRT, DIV, WRITE});
            r_done  <= (w_next == DONE);
        end
    end

    // Address, divider and coefficient datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num  <= '0;
            r_addr <= '0;
            r_q    <= '0;
            r_p    <= '0;
            r_cnt  <= '0;
            r_data <= '0;
        end else begin
            if ((r_state == IDLE) && bus.start) begin
                r_num  <= bus.num;
                r_addr <= '0;
            end else if (w_xfer && !w_last) begin
                r_addr <= r_addr + TWIDTH'(1);
            end
            if (w_sqrt_start) begin
                r_q <= {r_num, {FRAC{1'b0}}};
                r_p <= '0;
            end else if (r_state == DIV) begin
                r_q <= w_q_next;
                r_p <= w_p_next;
            end
            if ((r_state == SQRT) && w_sqrt_done) begin
                r_cnt <= CW'(DW - 1);
            end else if ((r_state == DIV) && (r_cnt != CW'(0))) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if ((r_state == DIV) && (r_cnt == CW'(0))) begin
                r_data <= w_k;
            end
        end
    end

    assign bus.tbl_clr  = r_clr;
    assign bus.tbl_wr   = r_wr;
    assign bus.tbl_data = r_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

`ifdef RSQRT_TBL_CHECK_EN
    logic [31:0] r_sum;

    // Checksum of transferred words, held after the run for readback
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= 32'd0;
        end else if (r_state == CLR) begin
            r_sum <= 32'd0;
        end else if (w_xfer) begin
            r_sum <= r_sum + 32'(r_data);
        end
    end

    assign bus.tbl_sum = r_sum;
`else
    assign bus.tbl_sum = 32'd0;
`endif

endmodule

// File: tb/tb_rsqrt_table_gen.sv
// Scoreboard bench for rsqrt_table_gen at TWIDTH=4: ordered words, handshake hold,
// ignored starts, mid-run reset and the optional checksum.
module tb_rsqrt_table_gen;
    localparam int TW     = 4;
    localparam int FR     = 4;
    localparam int NW     = 16;
    localparam int NWORDS = 1 << TW;
    localparam int LAT    = (TW + 2 + 2 * FR + 1) / 2 + NW + FR + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rsqrt_table_gen_if #(.TWIDTH(TW), .NUMW(NW)) bus ();

    rsqrt_table_gen #(.TWIDTH(TW), .FRAC(FR), .NUMW(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    int words[NWORDS];
    int xfer_cyc[NWORDS];
    int nxfer, nclr, ndone, cyc, clr_cyc;
    bit rnd_ready = 1'b0;
    logic prev_wait = 1'b0;
    logic [TW-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: brute-force root search and plain integer division
    function automatic int ref_k(input int a, input int n);
        longint rad;
        longint r;
        longint q;
        rad = longint'(4 * a + 2) << (2 * FR);
        r = 0;
        while ((r + 1) * (r + 1) <= rad) r++;
        q = (longint'(n) << FR) / r;
        return (q > NWORDS - 1) ? NWORDS - 1 : int'(q);
    endfunction

    // Consumer-side ready: tied high or random ~30% duty
    initial begin
        bus.tbl_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tbl_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: pulse counting, hold checks and scoreboard compare on each transfer
    initial begin
        int e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (bus.tbl_clr) begin
                    nclr++;
                    clr_cyc = cyc;
                end
                if (bus.done) ndone++;
                if (prev_wait) begin
                    check("hold_wr", 32'(bus.tbl_wr), 32'd1);
                    check("hold_data", 32'(bus.tbl_data), 32'(prev_data));
                end
                if (bus.tbl_wr && bus.tbl_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("word%0d", nxfer), 32'(bus.tbl_data), 32'(e));
                    end
                    if (nxfer < NWORDS) begin
                        words[nxfer]    = int'(bus.tbl_data);
                        xfer_cyc[nxfer] = cyc;
                    end
                    nxfer++;
                end
                prev_wait = bus.tbl_wr && !bus.tbl_ready;
                prev_data = bus.tbl_data;
            end else begin
                prev_wait = 1'b0;
            end
        end
    end

    task automatic pulse_start(input logic [NW-1:0] n);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.num   = n;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic arm(input logic [NW-1:0] n, output int sum);
        nxfer = 0;
        nclr  = 0;
        ndone = 0;
        sum   = 0;
        exp_q.delete();
        for (int a = 0; a < NWORDS; a++) begin
            exp_q.push_back(ref_k(a, int'(n)));
            sum += ref_k(a, int'(n));
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: extra starts in SQRT and WRITE
    task automatic do_run(input logic [NW-1:0] n, input int mode);
        int sum;
        bit inj_wr;
        arm(n, sum);
        inj_wr = 1'b0;
        pulse_start(n);
        if (mode == 2) bus.num = 16'hFFFF;
        for (int i = 0; i < 5000 && ndone == 0; i++) begin
            @(negedge clk);
            if (mode == 2 && (i == 3 || (bus.tbl_wr && !inj_wr))) begin
                if (i != 3) inj_wr = 1'b1;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("done_pulses", 32'(ndone), 32'd1);
        check("clr_pulses", 32'(nclr), 32'd1);
        check("xfers", 32'(nxfer), 32'(NWORDS));
        check("sb_left", 32'(exp_q.size()), 32'd0);
        check("busy_after", 32'(bus.busy), 32'd0);
`ifdef RSQRT_TBL_CHECK_EN
        check("tbl_sum", bus.tbl_sum, 32'(sum));
`else
        check("tbl_sum_zero", bus.tbl_sum, 32'd0);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_clr"},  32'(bus.tbl_clr),  32'd0);
        check({tag, "_wr"},   32'(bus.tbl_wr),   32'd0);
        check({tag, "_data"}, 32'(bus.tbl_data), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy),     32'd0);
        check({tag, "_done"}, 32'(bus.done),     32'd0);
        check({tag, "_sum"},  bus.tbl_sum,       32'd0);
    endtask

    initial begin
        int sum;
        bus.start = 1'b0;
        bus.num   = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        do_run(16'd8, 0);
        check("k0_num8", 32'(words[0]), 32'd5);
        check("k1_num8", 32'(words[1]), 32'd3);
        check("k15_num8", 32'(words[NWORDS-1]), 32'd1);
        check("first_latency", 32'(xfer_cyc[0] - clr_cyc), 32'(LAT));
        check("word_period", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'(LAT));

        do_run(16'd255, 0);
        check("k0_sat", 32'(words[0]), 32'd15);

        rnd_ready = 1'b1;
        do_run(16'd100, 1);
        rnd_ready = 1'b0;

        do_run(16'd8, 2);

        arm(16'd8, sum);
        pulse_start(16'd8);
        for (int i = 0; i < 2000 && nxfer < 4; i++) @(negedge clk);
        check("pre_rst_xfers", 32'(nxfer), 32'd4);
        repeat (10) @(negedge clk);
        check("mid_div_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midrun");
        rst = 1'b0;
        do_run(16'd8, 0);
        check("restart_k0", 32'(words[0]), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
